// File: rtl/thermostat_ctrl.sv
// rtl/thermostat_ctrl.sv - thermostat core: sampling, setpoint edit, hysteresis compare, heat/cool FSM
module thermostat_ctrl #(
  parameter int unsigned TEMP_W      = 8,
  parameter int unsigned TEMP_MIN    = 50,
  parameter int unsigned TEMP_MAX    = 90,
  parameter int unsigned DEFAULT_SET = 72,
  parameter int unsigned HYST        = 1,
  parameter int unsigned MIN_RUN_CYC = 4,
  parameter int unsigned MIN_OFF_CYC = 3,
  parameter int unsigned STALE_CYC   = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp_in,
  input  logic              Set,
  input  logic              Up,
  input  logic              Down,
  input  logic [1:0]        mode,
  output logic [TEMP_W-1:0] cur_temp,
  output logic [TEMP_W-1:0] setpoint,
  output logic [TEMP_W-1:0] edit_temp,
  output logic              editing,
  output logic              heat_on,
  output logic              cool_on,
  output logic [1:0]        state,
  output logic              fault
);

  localparam int unsigned STALE_W = $clog2(STALE_CYC + 1);
  localparam int unsigned RUN_W   = $clog2(MIN_RUN_CYC + 1);
  localparam int unsigned OFF_W   = $clog2(MIN_OFF_CYC + 1);

  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_HEAT = 2'd1;
  localparam logic [1:0] MODE_COOL = 2'd2;
  localparam logic [1:0] MODE_AUTO = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEAT    = 2'd1,
    ST_COOL    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [TEMP_W-1:0]   cur_temp_q, cur_temp_d;
  logic                have_temp_q, have_temp_d;
  logic [STALE_W-1:0]  stale_cnt_q, stale_cnt_d;
  logic [TEMP_W-1:0]   setpoint_q, setpoint_d;
  logic [TEMP_W-1:0]   edit_temp_q, edit_temp_d;
  logic                editing_q, editing_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic [OFF_W-1:0]    off_cnt_q, off_cnt_d;

  logic                fault_w;
  logic                cold, hot, run_done;
  logic [TEMP_W:0]     cur_ext, sp_ext, hyst_ext;

  assign fault_w  = (stale_cnt_q == STALE_W'(STALE_CYC));
  assign run_done = (run_cnt_q >= RUN_W'(MIN_RUN_CYC));

  // One extra bit keeps setpoint +/- HYST from wrapping near either end of the range
  assign cur_ext  = {1'b0, cur_temp_q};
  assign sp_ext   = {1'b0, setpoint_q};
  assign hyst_ext = (TEMP_W + 1)'(HYST);
  assign cold     = (cur_ext + hyst_ext) <= sp_ext;
  assign hot      = cur_ext >= (sp_ext + hyst_ext);

  // Sample capture and stale-sensor counter (saturating)
  always_comb begin
    cur_temp_d  = cur_temp_q;
    have_temp_d = have_temp_q;
    stale_cnt_d = stale_cnt_q;
    if (temp_valid) begin
      cur_temp_d  = temp_in;
      have_temp_d = 1'b1;
      stale_cnt_d = '0;
    end else if (!fault_w) begin
      stale_cnt_d = stale_cnt_q + 1'b1;
    end
  end

  // Setpoint editing: Set wins over Up/Down, simultaneous Up+Down is ignored
  always_comb begin
    setpoint_d  = setpoint_q;
    edit_temp_d = edit_temp_q;
    editing_d   = editing_q;
    if (Set) begin
      if (editing_q) begin
        setpoint_d = edit_temp_q;
        editing_d  = 1'b0;
      end
    end else if (Up && !Down) begin
      editing_d = 1'b1;
      if (edit_temp_q < TEMP_W'(TEMP_MAX)) edit_temp_d = edit_temp_q + 1'b1;
    end else if (Down && !Up) begin
      editing_d = 1'b1;
      if (edit_temp_q > TEMP_W'(TEMP_MIN)) edit_temp_d = edit_temp_q - 1'b1;
    end
  end

  // Demand FSM next-state plus run/off timers that restart on every state change
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    off_cnt_d = off_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (have_temp_q && !fault_w) begin
          if (cold && (mode == MODE_HEAT || mode == MODE_AUTO))      state_d = ST_HEAT;
          else if (hot && (mode == MODE_COOL || mode == MODE_AUTO))  state_d = ST_COOL;
        end
      end
      ST_HEAT: begin
        if (fault_w) state_d = ST_LOCKOUT;
        else if (run_done && (cur_temp_q >= setpoint_q || mode == MODE_OFF || mode == MODE_COOL))
          state_d = ST_LOCKOUT;
      end
      ST_COOL: begin
        if (fault_w) state_d = ST_LOCKOUT;
        else if (run_done && (cur_temp_q <= setpoint_q || mode == MODE_OFF || mode == MODE_HEAT))
          state_d = ST_LOCKOUT;
      end
      ST_LOCKOUT: begin
        if (off_cnt_q == OFF_W'(MIN_OFF_CYC - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      run_cnt_d = '0;
      off_cnt_d = '0;
    end else begin
      if ((state_q == ST_HEAT || state_q == ST_COOL) && !run_done)
        run_cnt_d = run_cnt_q + 1'b1;
      if (state_q == ST_LOCKOUT && off_cnt_q < OFF_W'(MIN_OFF_CYC))
        off_cnt_d = off_cnt_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      cur_temp_q  <= '0;
      have_temp_q <= 1'b0;
      stale_cnt_q <= '0;
      setpoint_q  <= TEMP_W'(DEFAULT_SET);
      edit_temp_q <= TEMP_W'(DEFAULT_SET);
      editing_q   <= 1'b0;
      run_cnt_q   <= '0;
      off_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_temp_q  <= cur_temp_d;
      have_temp_q <= have_temp_d;
      stale_cnt_q <= stale_cnt_d;
      setpoint_q  <= setpoint_d;
      edit_temp_q <= edit_temp_d;
      editing_q   <= editing_d;
      run_cnt_q   <= run_cnt_d;
      off_cnt_q   <= off_cnt_d;
    end
  end

  assign cur_temp  = cur_temp_q;
  assign setpoint  = setpoint_q;
  assign edit_temp = edit_temp_q;
  assign editing   = editing_q;
  assign heat_on   = (state_q == ST_HEAT);
  assign cool_on   = (state_q == ST_COOL);
  assign state     = state_q;
  assign fault     = fault_w;

endmodule

// File: tb/tb_thermostat_ctrl.sv
// tb/tb_thermostat_ctrl.sv - directed-vector bench for thermostat_ctrl
module tb_thermostat_ctrl;

  logic       clk = 1'b0;
  logic       Reset;
  logic       temp_valid;
  logic [7:0] temp_in;
  logic       Set, Up, Down;
  logic [1:0] mode;
  logic [7:0] cur_temp, setpoint, edit_temp;
  logic       editing, heat_on, cool_on, fault;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  thermostat_ctrl dut (
    .clk        (clk),
    .Reset      (Reset),
    .temp_valid (temp_valid),
    .temp_in    (temp_in),
    .Set        (Set),
    .Up         (Up),
    .Down       (Down),
    .mode       (mode),
    .cur_temp   (cur_temp),
    .setpoint   (setpoint),
    .edit_temp  (edit_temp),
    .editing    (editing),
    .heat_on    (heat_on),
    .cool_on    (cool_on),
    .state      (state),
    .fault      (fault)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample(input logic [7:0] t);
    temp_in    = t;
    temp_valid = 1'b1;
    tick(1);
    temp_valid = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic u, input logic d, input int n);
    repeat (n) begin
      Set = s; Up = u; Down = d;
      tick(1);
      Set = 1'b0; Up = 1'b0; Down = 1'b0;
    end
  endtask

  initial begin
    Reset = 1'b0; temp_valid = 1'b0; temp_in = 8'd0;
    Set = 1'b0; Up = 1'b0; Down = 1'b0; mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cur_temp", cur_temp, 0);
    check("rst_setpoint", setpoint, 72);
    check("rst_edit_temp", edit_temp, 72);
    check("rst_editing", editing, 0);
    check("rst_state", state, 0);
    check("rst_heat_cool", {heat_on, cool_on}, 0);
    check("rst_fault", fault, 0);

    // No samples: fault appears on the 16th edge
    Reset = 1'b1;
    tick(15);
    check("stale_15_fault", fault, 0);
    tick(1);
    check("stale_16_fault", fault, 1);
    check("stale_state", state, 0);

    // Heat run with minimum run time then lockout
    mode = 2'd1;
    sample(8'd70);
    check("heat_cur_temp", cur_temp, 70);
    check("heat_fault_clr", fault, 0);
    check("heat_not_yet", heat_on, 0);
    tick(1);
    check("heat_on", heat_on, 1);
    sample(8'd72);
    check("heat_run1", state, 1);
    tick(3);
    check("heat_run4", heat_on, 1);
    tick(1);
    check("heat_lockout", state, 3);
    check("heat_lockout_off", heat_on, 0);
    tick(2);
    check("lockout_hold", state, 3);
    tick(1);
    check("lockout_idle", state, 0);

    // Auto mode cooling, then stale sensor forces lockout
    mode = 2'd3;
    sample(8'd74);
    tick(1);
    check("auto_cool_on", cool_on, 1);
    check("auto_state", state, 2);
    tick(14);
    check("cool_fault_15", fault, 0);
    tick(1);
    check("cool_fault_16", fault, 1);
    check("cool_still_on", cool_on, 1);
    tick(1);
    check("fault_lockout", state, 3);
    check("fault_cool_off", cool_on, 0);
    tick(3);
    check("fault_idle", state, 0);
    check("fault_held", fault, 1);
    sample(8'd74);
    check("fault_cleared", fault, 0);
    tick(1);
    check("recool", state, 2);
    mode = 2'd0;
    tick(10);
    check("off_idle", state, 0);

    // Setpoint editing
    pulse(1'b0, 1'b1, 1'b0, 25);
    check("up_sat", edit_temp, 90);
    check("up_editing", editing, 1);
    check("up_sp_hold", setpoint, 72);
    pulse(1'b1, 1'b0, 1'b0, 1);
    check("set_sp", setpoint, 90);
    check("set_editing", editing, 0);
    pulse(1'b0, 1'b1, 1'b1, 1);
    check("updown_none", edit_temp, 90);
    pulse(1'b0, 1'b0, 1'b1, 42);
    check("down_sat", edit_temp, 50);
    pulse(1'b1, 1'b1, 1'b0, 1);
    check("set_over_up_sp", setpoint, 50);
    check("set_over_up_edit", edit_temp, 50);
    check("set_over_up_editing", editing, 0);

    // Heat at the bottom of the range
    mode = 2'd1;
    sample(8'd49);
    tick(1);
    check("low_heat", heat_on, 1);
    check("low_cool", cool_on, 0);

    // Asynchronous reset mid-run
    #2;
    Reset = 1'b0;
    #1;
    check("arst_heat", heat_on, 0);
    check("arst_state", state, 0);
    check("arst_setpoint", setpoint, 72);
    check("arst_cur_temp", cur_temp, 0);
    tick(1);
    Reset = 1'b1;
    tick(2);
    check("arst_stay_idle", state, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
